// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, shifts one
// command byte out on device clock falls and checks the device ACK bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Lane 0 is the PS/2 clock, lane 1 the PS/2 data.
  logic [1:0]                 sync_a, sync_b;
  logic [1:0][FILTER_LEN-1:0] hist;
  logic [1:0]                 filt;
  logic                       clk_prev;
  logic                       fall;

  // NOTE: reset here is synchronous and active-high because these pins are shared with the
  // existing receive path that uses the same scheme.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= '1;
      sync_b   <= '1;
      hist     <= '1;
      filt     <= '1;
      clk_prev <= 1'b1;
    end else begin
      sync_a   <= {ps2_data_in, ps2_clk_in};
      sync_b   <= sync_a;
      clk_prev <= filt[0];
      // A level is accepted only after FILTER_LEN identical samples; otherwise hold.
      for (int i = 0; i < 2; i++) begin
        hist[i] <= {hist[i][FILTER_LEN-2:0], sync_b[i]};
        if (&hist[i])
          filt[i] <= 1'b1;
        else if (~|hist[i])
          filt[i] <= 1'b0;
      end
    end
  end

  assign fall = clk_prev & ~filt[0];

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       idx, idx_d;
  logic [9:0]       frame, frame_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      frame     <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      frame     <= frame_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // NOTE: every signal gets its default first so no path through the case leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    idx_d     = idx;
    frame_d   = frame;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INHIBIT_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          cnt_d     = '0;
          data_oe_d = ~frame[idx];
          idx_d     = idx + 4'd1;
          if (idx == 4'd9)
            state_d = S_ACK;
        end else if (cnt == TIMEOUT_LAST) begin
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (!filt[1]) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (filt[0] && filt[1]) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt == TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready    = (state == S_IDLE);
  assign busy        = ~tx_ready;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_START);
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the host and a byte-level reference model predicts data, parity, stop and outcome.
module tb_ps2_host_tx;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 500;
  localparam int FLT     = 4;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Wired-AND open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN    (FLT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pulse bookkeeping, sampled on the inactive edge.
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   overlap_cnt = 0;
  int   oe_bad_cnt = 0;
  logic err_prev = 1'b0;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (done && error) overlap_cnt <= overlap_cnt + 1;
    if ((error || err_prev) && (ps2_clk_oe || ps2_data_oe)) oe_bad_cnt <= oe_bad_cnt + 1;
    err_prev <= error;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Device side: wait for request-to-send (clock released, data held low).
  task automatic dev_wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ps2_clk_in && !ps2_data_in) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One device clock pulse; the data line is read just before the rising edge.
  task automatic dev_pulse(output logic b);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    b = ps2_data_in;
    dev_clk_low = 1'b0;
  endtask

  task automatic dev_ack(input bit ack);
    repeat (HALF / 2) @(negedge clk);
    if (ack) dev_data_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic dev_frame(input bit ack, output logic [9:0] bits, output bit ok);
    logic b;
    bits = '0;
    dev_wait_rts(ok);
    if (!ok) return;
    for (int i = 0; i < 10; i++) begin
      dev_pulse(b);
      bits[i] = b;
    end
    dev_ack(ack);
  endtask

  // Full transaction with expectations from the byte itself (exp_par from table or model).
  task automatic run_frame(input logic [7:0] d, input bit ack, input bit exp_par, input string tag);
    int         d0 = done_cnt;
    int         e0 = err_cnt;
    logic [9:0] bits;
    bit         ok, rdy;
    send_req(d);
    dev_frame(ack, bits, ok);
    check({tag, "_rts"}, 32'(ok), 32'd1);
    wait_ready(rdy);
    repeat (3) @(negedge clk);
    check({tag, "_data"}, 32'(bits[7:0]), 32'(d));
    check({tag, "_parity"}, 32'(bits[8]), 32'(exp_par));
    check({tag, "_stop"}, 32'(bits[9]), 32'd1);
    check({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check({tag, "_error"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check({tag, "_ready"}, 32'(rdy), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_parity;
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] bits5;
  bit         ok5;

  initial begin
    int         n, d0, e0;
    logic [9:0] bits;
    logic       b;
    bit         ok, rdy;
    logic [7:0] rd;
    bit         rack;

    vecs[0] = '{8'h00, 1'b1, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h80, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_out", {28'd0, tx_ready, busy, done, error}, 32'b1000);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_out", {28'd0, tx_ready, busy, done, error}, 32'b1000);

    // 0xED with inhibit length and start-bit timing.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'hED);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(n), 32'(INHIBIT));
    check("start_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b11);
    @(negedge clk);
    check("send_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
    dev_frame(1'b1, bits, ok);
    check("ed_rts", 32'(ok), 32'd1);
    check("ed_frame", 32'(bits), 32'h3ED);
    wait_ready(rdy);
    repeat (3) @(negedge clk);
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_error", 32'(err_cnt - e0), 32'd0);
    check("ed_ready", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_parity, $sformatf("vec%0d", i));

    // Randomized bytes against the reference parity rule (odd overall parity).
    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      run_frame(rd, rack, ($countones(rd) % 2) == 0, $sformatf("rnd%0d", i));
    end

    // Device never clocks: timeout counted from the first SEND cycle.
    e0 = err_cnt;
    d0 = done_cnt;
    send_req(8'hAA);
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!error && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_len", 32'(n), 32'(TIMEOUT));
    check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_done", 32'(done_cnt - d0), 32'd0);

    // Request while busy is dropped.
    d0 = done_cnt;
    send_req(8'hF4);
    fork
      dev_frame(1'b1, bits5, ok5);
      begin
        repeat (150) @(negedge clk);
        check("busy_mid", 32'(busy), 32'd1);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check("f4_frame", 32'(bits5), 32'h2F4);
    wait_ready(rdy);
    repeat (100) @(negedge clk);
    check("f4_done", 32'(done_cnt - d0), 32'd1);
    check("f4_no_queue", {30'd0, tx_ready, ps2_clk_oe}, 32'b10);

    // Reset in the middle of bit 4.
    d0 = done_cnt;
    e0 = err_cnt;
    send_req(8'h96);
    dev_wait_rts(ok);
    check("rst_mid_rts", 32'(ok), 32'd1);
    for (int i = 0; i < 4; i++) dev_pulse(b);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_state", {28'd0, tx_ready, ps2_clk_oe, ps2_data_oe, done | error}, 32'b1000);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    run_frame(8'hFF, 1'b1, 1'b1, "after_rst");

    check("no_overlap", 32'(overlap_cnt), 32'd0);
    check("error_oe_released", 32'(oe_bad_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
